// File: rtl/multi_edge_detect.sv
// multi_edge_detect
//
// Multi-channel edge detector for asynchronous status and strobe pins. Each channel has:
//   - a SYNC_STAGES-deep synchroniser chain with no logic between the stages,
//   - a glitch filter that accepts a new level only after the synchronised input has
//     disagreed with the stable level for filt_len+1 consecutive cycles,
//   - registered one-cycle rise/fall pulses on each accepted change,
//   - sticky rise/fall flags, gated by per-channel enables and cleared by clr (set wins).
// All sticky flags are OR-ed into irq.
//
// Parameters:
//   N_CH        number of independent channels
//   SYNC_STAGES synchroniser depth, legal range 2..4
//   FILT_BITS   width of the filter counter and of filt_len
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst_n      synchronous active-low reset
//   async_sig  [N_CH]      asynchronous inputs
//   filt_len   [FILT_BITS] filter length L, shared by all channels, quasi-static
//   rise_en    [N_CH]      enables setting of rise_flag
//   fall_en    [N_CH]      enables setting of fall_flag
//   clr        [N_CH]      write-1-to-clear for both sticky flags of a channel
//   level      [N_CH]      filtered stable level
//   rise       [N_CH]      one-cycle pulse on each accepted 0->1 change
//   fall       [N_CH]      one-cycle pulse on each accepted 1->0 change
//   rise_flag  [N_CH]      sticky rise event
//   fall_flag  [N_CH]      sticky fall event
//   irq                    OR of all sticky flags
module multi_edge_detect #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      async_sig,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic [N_CH-1:0]      rise_en,
  input  logic [N_CH-1:0]      fall_en,
  input  logic [N_CH-1:0]      clr,
  output logic [N_CH-1:0]      level,
  output logic [N_CH-1:0]      rise,
  output logic [N_CH-1:0]      fall,
  output logic [N_CH-1:0]      rise_flag,
  output logic [N_CH-1:0]      fall_flag,
  output logic                 irq
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   stab_q, stab_d;
    logic [FILT_BITS-1:0]   cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   rise_flag_q, rise_flag_d;
    logic                   fall_flag_q, fall_flag_d;

    // Plain shift chain; sync_q[0] is the metastability-catching stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Glitch filter. cnt counts mismatch cycles already seen; any agreement with stab
    // throws the run away. The >= compare lets a mid-count reduction of filt_len accept
    // at once, and bounds cnt to filt_len so it can never wrap.
    always_comb begin
      stab_d = stab_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != stab_q) begin
        if (cnt_q >= filt_len) begin
          stab_d = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + FILT_BITS'(1);
        end
      end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
      rise_flag_d = (rise_flag_q & ~clr[i]) | (rise_q & rise_en[i]);
      fall_flag_d = (fall_flag_q & ~clr[i]) | (fall_q & fall_en[i]);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stab_q      <= 1'b0;
        cnt_q       <= '0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
        rise_flag_q <= 1'b0;
        fall_flag_q <= 1'b0;
      end else begin
        stab_q      <= stab_d;
        cnt_q       <= cnt_d;
        rise_q      <= rise_d;
        fall_q      <= fall_d;
        rise_flag_q <= rise_flag_d;
        fall_flag_q <= fall_flag_d;
      end
    end

    assign level[i]     = stab_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
    assign rise_flag[i] = rise_flag_q;
    assign fall_flag[i] = fall_flag_q;
  end : g_ch

  // Combinational so the interrupt follows the flag registers with no extra cycle.
  assign irq = |{rise_flag, fall_flag};

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect. Three instances cover the parameter corners:
//   u_dut0: N_CH=8,  SYNC_STAGES=2, FILT_BITS=4 (defaults, used by the directed tests)
//   u_dut1: N_CH=32, SYNC_STAGES=4, FILT_BITS=8
//   u_dut2: N_CH=1,  SYNC_STAGES=2, FILT_BITS=1
// A cycle-level behavioural model follows every instance; all outputs are compared on
// every falling edge, and the directed tests add literal expectations.
module tb_multi_edge_detect;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, one set per instance (upper bits unused for narrow instances)
  logic        rstn  [NI];
  logic [31:0] a_sig [NI];
  logic [31:0] ren   [NI];
  logic [31:0] fen   [NI];
  logic [31:0] clr_s [NI];
  logic [7:0]  flen  [NI];

  logic [7:0]  lvl0, rise0, fall0, rf0, ff0;
  logic        irq0;
  logic [31:0] lvl1, rise1, fall1, rf1, ff1;
  logic        irq1;
  logic [0:0]  lvl2, rise2, fall2, rf2, ff2;
  logic        irq2;

  // Outputs widened to 32 bits for uniform checking
  logic [31:0] o_lvl [NI];
  logic [31:0] o_rise[NI];
  logic [31:0] o_fall[NI];
  logic [31:0] o_rf  [NI];
  logic [31:0] o_ff  [NI];
  logic [31:0] o_irq [NI];

  assign o_lvl[0]  = {24'b0, lvl0};
  assign o_rise[0] = {24'b0, rise0};
  assign o_fall[0] = {24'b0, fall0};
  assign o_rf[0]   = {24'b0, rf0};
  assign o_ff[0]   = {24'b0, ff0};
  assign o_irq[0]  = {31'b0, irq0};
  assign o_lvl[1]  = lvl1;
  assign o_rise[1] = rise1;
  assign o_fall[1] = fall1;
  assign o_rf[1]   = rf1;
  assign o_ff[1]   = ff1;
  assign o_irq[1]  = {31'b0, irq1};
  assign o_lvl[2]  = {31'b0, lvl2};
  assign o_rise[2] = {31'b0, rise2};
  assign o_fall[2] = {31'b0, fall2};
  assign o_rf[2]   = {31'b0, rf2};
  assign o_ff[2]   = {31'b0, ff2};
  assign o_irq[2]  = {31'b0, irq2};

  multi_edge_detect #(.N_CH(8), .SYNC_STAGES(2), .FILT_BITS(4)) u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .async_sig(a_sig[0][7:0]), .filt_len(flen[0][3:0]),
    .rise_en(ren[0][7:0]), .fall_en(fen[0][7:0]), .clr(clr_s[0][7:0]),
    .level(lvl0), .rise(rise0), .fall(fall0), .rise_flag(rf0), .fall_flag(ff0), .irq(irq0)
  );

  multi_edge_detect #(.N_CH(32), .SYNC_STAGES(4), .FILT_BITS(8)) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .async_sig(a_sig[1]), .filt_len(flen[1]),
    .rise_en(ren[1]), .fall_en(fen[1]), .clr(clr_s[1]),
    .level(lvl1), .rise(rise1), .fall(fall1), .rise_flag(rf1), .fall_flag(ff1), .irq(irq1)
  );

  multi_edge_detect #(.N_CH(1), .SYNC_STAGES(2), .FILT_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rstn[2]), .async_sig(a_sig[2][0:0]), .filt_len(flen[2][0:0]),
    .rise_en(ren[2][0:0]), .fall_en(fen[2][0:0]), .clr(clr_s[2][0:0]),
    .level(lvl2), .rise(rise2), .fall(fall2), .rise_flag(rf2), .fall_flag(ff2), .irq(irq2)
  );

  function automatic int nch(input int k);
    case (k)
      0:       return 8;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  function automatic int nsync(input int k);
    return (k == 1) ? 4 : 2;
  endfunction

  function automatic int fbits(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] chmask(input int k);
    return (nch(k) == 32) ? 32'hffff_ffff : ((32'd1 << nch(k)) - 32'd1);
  endfunction

  // ---------------------------------------------------------------------------------------
  // Behavioural model. m_hist holds the last samples of each input (bit 0 newest), so the
  // synchronised value is simply the input as it was nsync edges ago. m_run is the length
  // of the current run of cycles in which that value has disagreed with the level.
  // ---------------------------------------------------------------------------------------
  logic [3:0]  m_hist [NI][32];
  int          m_run  [NI][32];
  logic [31:0] m_lvl  [NI];
  logic [31:0] m_rise [NI];
  logic [31:0] m_fall [NI];
  logic [31:0] m_rf   [NI];
  logic [31:0] m_ff   [NI];

  task automatic model_step(input int k);
    int          lim;
    logic        s;
    logic [31:0] prev_rise;
    logic [31:0] prev_fall;
    lim = int'(flen[k]) & ((1 << fbits(k)) - 1);
    if (!rstn[k]) begin
      m_lvl[k]  = '0;
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_rf[k]   = '0;
      m_ff[k]   = '0;
      for (int c = 0; c < 32; c++) begin
        m_hist[k][c] = '0;
        m_run[k][c]  = 0;
      end
    end else begin
      prev_rise = m_rise[k];
      prev_fall = m_fall[k];
      m_rf[k] = (m_rf[k] & ~clr_s[k]) | (prev_rise & ren[k]);
      m_ff[k] = (m_ff[k] & ~clr_s[k]) | (prev_fall & fen[k]);
      for (int c = 0; c < nch(k); c++) begin
        s = m_hist[k][c][nsync(k)-1];
        m_rise[k][c] = 1'b0;
        m_fall[k][c] = 1'b0;
        if (s != m_lvl[k][c]) begin
          // This cycle is disagreement number m_run+1; L+1 of them accepts.
          if (m_run[k][c] + 1 >= lim + 1) begin
            m_lvl[k][c]  = s;
            m_rise[k][c] = s;
            m_fall[k][c] = ~s;
            m_run[k][c]  = 0;
          end else begin
            m_run[k][c] = m_run[k][c] + 1;
          end
        end else begin
          m_run[k][c] = 0;
        end
        m_hist[k][c] = {m_hist[k][c][2:0], a_sig[k][c]};
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // ---------------------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        cmp($sformatf("u%0d.level", k), o_lvl[k] & chmask(k), m_lvl[k] & chmask(k));
        cmp($sformatf("u%0d.rise", k), o_rise[k] & chmask(k), m_rise[k] & chmask(k));
        cmp($sformatf("u%0d.fall", k), o_fall[k] & chmask(k), m_fall[k] & chmask(k));
        cmp($sformatf("u%0d.rise_flag", k), o_rf[k] & chmask(k), m_rf[k] & chmask(k));
        cmp($sformatf("u%0d.fall_flag", k), o_ff[k] & chmask(k), m_ff[k] & chmask(k));
        cmp($sformatf("u%0d.irq", k), o_irq[k],
            {31'b0, |((m_rf[k] | m_ff[k]) & chmask(k))});
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------------------
  // Directed tests, then random traffic on all instances
  // ---------------------------------------------------------------------------------------
  logic [31:0] seen;

  initial begin
    for (int k = 0; k < NI; k++) begin
      rstn[k]  = 1'b0;
      a_sig[k] = '0;
      ren[k]   = '0;
      fen[k]   = '0;
      clr_s[k] = '0;
      flen[k]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) rstn[k] = 1'b1;
    chk_on = 1'b1;
    cmp("reset.level", o_lvl[0], 32'h0);
    cmp("reset.flags", o_rf[0] | o_ff[0], 32'h0);
    cmp("reset.irq", o_irq[0], 32'h0);

    // Basic rise then fall, L=0: rise at edge 3, fall at edge 23
    @(negedge clk); a_sig[0][0] = 1'b1;
    wait_edges(2); cmp("t1.rise_e2", o_rise[0], 32'h0);
    wait_edges(1); cmp("t1.rise_e3", o_rise[0], 32'h1);
    cmp("t1.level_e3", o_lvl[0], 32'h1);
    cmp("t1.model_rise_e3", m_rise[0], 32'h1);
    wait_edges(1); cmp("t1.rise_e4", o_rise[0], 32'h0);
    repeat (16) @(posedge clk);
    @(negedge clk); a_sig[0][0] = 1'b0;
    wait_edges(2); cmp("t1.fall_e22", o_fall[0], 32'h0);
    wait_edges(1); cmp("t1.fall_e23", o_fall[0], 32'h1);
    cmp("t1.level_e23", o_lvl[0], 32'h0);
    cmp("t1.irq_masked", o_irq[0], 32'h0);

    // Glitch rejection, L=3 on ch2
    @(negedge clk); flen[0] = 8'd3;
    @(negedge clk); a_sig[0][2] = 1'b1;
    repeat (3) @(negedge clk);
    a_sig[0][2] = 1'b0;
    seen = '0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | o_rise[0] | o_lvl[0];
    end
    cmp("t2.glitch_3cyc", seen & 32'h4, 32'h0);
    @(negedge clk); a_sig[0][2] = 1'b1;
    wait_edges(4);
    @(negedge clk); a_sig[0][2] = 1'b0;
    wait_edges(1); cmp("t2.rise_e5", o_rise[0], 32'h0);
    wait_edges(1); cmp("t2.rise_e6", o_rise[0], 32'h4);
    cmp("t2.level_e6", o_lvl[0], 32'h4);
    cmp("t2.model_level_e6", m_lvl[0], 32'h4);
    wait_edges(4); cmp("t2.fall_e10", o_fall[0], 32'h4);

    // Sticky flags, enables, clear on ch1
    @(negedge clk);
    flen[0] = 8'd0; ren[0] = 32'h2; fen[0] = 32'h0; a_sig[0][1] = 1'b1;
    wait_edges(3); cmp("t3.rise", o_rise[0], 32'h2);
    wait_edges(1); cmp("t3.rise_flag", o_rf[0], 32'h2);
    cmp("t3.irq_set", o_irq[0], 32'h1);
    @(negedge clk); a_sig[0][1] = 1'b0;
    wait_edges(3); cmp("t3.fall", o_fall[0], 32'h2);
    wait_edges(1); cmp("t3.fall_flag_masked", o_ff[0], 32'h0);
    cmp("t3.rise_flag_kept", o_rf[0], 32'h2);
    @(negedge clk); a_sig[0][1] = 1'b1;
    wait_edges(3); cmp("t3.rise2", o_rise[0], 32'h2);
    @(negedge clk); clr_s[0] = 32'h2;
    wait_edges(1); cmp("t3.set_beats_clr", o_rf[0], 32'h2);
    @(negedge clk); clr_s[0] = 32'h0;
    @(negedge clk); clr_s[0] = 32'h2;
    wait_edges(1); cmp("t3.clr_flag", o_rf[0], 32'h0);
    cmp("t3.clr_irq", o_irq[0], 32'h0);
    @(negedge clk); clr_s[0] = 32'h0;

    // Filter length reduced mid-count on ch3
    @(negedge clk); flen[0] = 8'd15; a_sig[0][3] = 1'b1;
    wait_edges(10); cmp("t4.rise_pre", o_rise[0], 32'h0);
    cmp("t4.level_pre", o_lvl[0] & 32'h8, 32'h0);
    @(negedge clk); flen[0] = 8'd2;
    wait_edges(1); cmp("t4.rise_accept", o_rise[0], 32'h8);
    seen = '0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | o_rise[0] | o_fall[0];
    end
    cmp("t4.single_pulse", seen & 32'h8, 32'h0);

    // Reset with flags set and a count in progress; ch5 held high through release
    @(negedge clk); flen[0] = 8'd0; ren[0] = 32'hff; a_sig[0][6] = 1'b1;
    wait_edges(4); cmp("t5.flag_pre", o_rf[0] & 32'h40, 32'h40);
    cmp("t5.irq_pre", o_irq[0], 32'h1);
    @(negedge clk); flen[0] = 8'd5; a_sig[0][4] = 1'b1; a_sig[0][5] = 1'b1;
    wait_edges(4);
    @(negedge clk); rstn[0] = 1'b0; a_sig[0] = 32'h20;
    wait_edges(1); cmp("t5.level_rst", o_lvl[0], 32'h0);
    cmp("t5.pulses_rst", o_rise[0] | o_fall[0], 32'h0);
    cmp("t5.flags_rst", o_rf[0] | o_ff[0], 32'h0);
    cmp("t5.irq_rst", o_irq[0], 32'h0);
    @(negedge clk); rstn[0] = 1'b1;
    wait_edges(7); cmp("t5.rise_e7", o_rise[0], 32'h0);
    wait_edges(1); cmp("t5.rise_e8", o_rise[0], 32'h20);
    cmp("t5.level_e8", o_lvl[0], 32'h20);

    // Random toggling on every instance; the model comparison carries the checking
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (((t / 256) % 2) == 0) begin
          a_sig[k] = a_sig[k] ^ ($urandom & $urandom & $urandom);
        end else begin
          a_sig[k] = a_sig[k] ^ ($urandom & $urandom & $urandom & $urandom & $urandom);
        end
        clr_s[k] = $urandom & $urandom & $urandom & $urandom;
        if ((t % 64) == 0) begin
          ren[k]  = $urandom;
          fen[k]  = $urandom;
          flen[k] = 8'($urandom_range(0, (k == 2) ? 1 : 5));
        end
        rstn[k] = ($urandom_range(0, 299) != 0);
      end
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rstn[k] = 1'b1;
    repeat (20) @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
